addsub_seq_arbiter: RTL and testbench

ADDSUB_SEQ_ARBITER -- requirements
Module: addsub_seq_arbiter

---
 rtl/addsub_seq_pkg.sv | 15 +
 rtl/addsub_nibble.sv | 28 ++
 rtl/addsub_seq_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_addsub_seq_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_seq_pkg.sv
// addsub_seq_pkg: shared state encoding, nibble width and requester id type
// for the nibble-serial add/sub arbiter.
package addsub_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/addsub_nibble.sv
// addsub_nibble: purely combinational 4-bit adder slice. Besides the sum and
// carry out it exposes the carry into the MSB so the caller can derive signed
// overflow on the most significant nibble.
module addsub_nibble
  import addsub_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                c_msb
);

  logic [NIBBLE_W-1:0] w_low;
  logic [1:0]          w_high;

  // Low three bits first so the carry into the MSB is visible on its own
  assign w_low  = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, b[NIBBLE_W-2:0]}
                + {{(NIBBLE_W-1){1'b0}}, cin};
  assign w_high = {1'b0, a[NIBBLE_W-1]} + {1'b0, b[NIBBLE_W-1]}
                + {1'b0, w_low[NIBBLE_W-1]};

  assign sum   = {w_high[0], w_low[NIBBLE_W-2:0]};
  assign cout  = w_high[1];
  assign c_msb = w_low[NIBBLE_W-1];

endmodule

// File: rtl/addsub_seq_arbiter.sv
// addsub_seq_arbiter: two requesters share one nibble-serial adder/subtractor.
// A round-robin arbiter accepts one operation in IDLE, the operands are then
// walked through a single 4-bit adder LSB first (one nibble per cycle), and the
// result is held in DONE until the consumer takes it.
// Optional feature: define ADDSUB_SEQ_OVF_EN to build the signed-overflow flag;
// otherwise res_ovf_o is constant 0.
module addsub_seq_arbiter
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic             req0_sub_i,

  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  input  logic             req1_sub_i,

  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_data_o,
  output logic             res_carry_o,
  output logic             res_id_o,
  output logic             res_ovf_o
);

  localparam int NIB_CNT = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB_CNT - 1);

  state_e              r_state;
  state_e              w_state_next;
  req_id_t             r_last_grant;
  req_id_t             r_id;
  req_id_t             w_grant;
  logic                w_accept;
  logic                w_last_nib;

  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_data;
  logic                r_sub;
  logic                r_carry;
  logic                r_res_carry;
  logic [IDX_W-1:0]    r_idx;

  logic [WIDTH-1:0]    w_sel_a;
  logic [WIDTH-1:0]    w_sel_b;
  logic                w_sel_sub;

  logic [NIBBLE_W-1:0] w_sum;
  logic                w_cout;
  logic                w_c_msb;

  assign w_last_nib = (r_idx == LAST_IDX);

  // Round-robin pick: a lone requester wins, a tie goes to whoever did not win last
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      w_grant = ~r_last_grant;
    end else if (req1_valid_i) begin
      w_grant = 1'b1;
    end
  end

  assign w_sel_a   = w_grant ? req1_a_i   : req0_a_i;
  assign w_sel_b   = w_grant ? req1_b_i   : req0_b_i;
  assign w_sel_sub = w_grant ? req1_sub_i : req0_sub_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus the request handshake; ready only exists while idle
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0_valid_i || req1_valid_i) begin
          w_accept     = 1'b1;
          w_state_next = CALC;
          req0_ready_o = (w_grant == 1'b0);
          req1_ready_o = (w_grant == 1'b1);
        end
      end
      CALC: begin
        if (w_last_nib) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (res_ready_i) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // The one shared nibble adder; operands shift down so it always sees nibble 0
  addsub_nibble u_nibble (
    .a    (r_a[NIBBLE_W-1:0]),
    .b    (r_b[NIBBLE_W-1:0]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout),
    .c_msb(w_c_msb)
  );

  // Operand capture on accept (subtract = add inverted b with carry-in 1), then nibble stepping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a          <= '0;
      r_b          <= '0;
      r_sub        <= 1'b0;
      r_id         <= 1'b0;
      r_idx        <= '0;
      r_carry      <= 1'b0;
      r_last_grant <= 1'b1;
      r_data       <= '0;
      r_res_carry  <= 1'b0;
    end else if (w_accept) begin
      r_a          <= w_sel_a;
      r_b          <= w_sel_sub ? ~w_sel_b : w_sel_b;
      r_sub        <= w_sel_sub;
      r_id         <= w_grant;
      r_last_grant <= w_grant;
      r_idx        <= '0;
      r_carry      <= w_sel_sub;
    end else if (r_state == CALC) begin
      r_a     <= r_a >> NIBBLE_W;
      r_b     <= r_b >> NIBBLE_W;
      r_carry <= w_cout;
      r_idx   <= r_idx + 1'b1;
      r_data[r_idx*NIBBLE_W +: NIBBLE_W] <= w_sum;
      if (w_last_nib) begin
        r_res_carry <= r_sub ? ~w_cout : w_cout;
      end
    end
  end

  assign res_valid_o = (r_state == DONE);
  assign res_data_o  = r_data;
  assign res_carry_o = r_res_carry;
  assign res_id_o    = r_id;

`ifdef ADDSUB_SEQ_OVF_EN
  logic r_ovf;

  // Signed overflow is the disagreement of the carries around the MSB of the top nibble
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ovf <= 1'b0;
    end else if ((r_state == CALC) && w_last_nib) begin
      r_ovf <= w_c_msb ^ w_cout;
    end
  end

  assign res_ovf_o = r_ovf;
`else
  logic w_unused_c_msb;

  assign w_unused_c_msb = w_c_msb;
  assign res_ovf_o      = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_seq_arbiter.sv
// tb_addsub_seq_arbiter: randomized, scoreboarded bench for addsub_seq_arbiter.
// The driver pushes the expected result whenever its own round-robin model
// says a request is accepted; an independent monitor pops and compares each
// presented result. Honors ADDSUB_SEQ_OVF_EN for the overflow expectation.
module tb_addsub_seq_arbiter;

  localparam int W   = 16;
  localparam int LAT = W / 4 + 1;

  typedef struct {
    logic [W-1:0] data;
    logic         carry;
    logic         id;
    logic         ovf;
    int           acceptCyc;
  } expect_t;

  expect_t expQ[$];

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         req0_valid_i, req0_ready_o, req0_sub_i;
  logic [W-1:0] req0_a_i, req0_b_i;
  logic         req1_valid_i, req1_ready_o, req1_sub_i;
  logic [W-1:0] req1_a_i, req1_b_i;
  logic         res_valid_o, res_ready_i, res_carry_o, res_id_o, res_ovf_o;
  logic [W-1:0] res_data_o;

  int   nChecks = 0;
  int   nErrors = 0;
  int   cyc = 0;
  logic lastGrant = 1'b1;
  logic prevValid = 1'b0;
  logic lateFlag = 1'b0;

  addsub_seq_arbiter #(.WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req0_valid_i(req0_valid_i),
    .req0_ready_o(req0_ready_o),
    .req0_a_i    (req0_a_i),
    .req0_b_i    (req0_b_i),
    .req0_sub_i  (req0_sub_i),
    .req1_valid_i(req1_valid_i),
    .req1_ready_o(req1_ready_o),
    .req1_a_i    (req1_a_i),
    .req1_b_i    (req1_b_i),
    .req1_sub_i  (req1_sub_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_data_o  (res_data_o),
    .res_carry_o (res_carry_o),
    .res_id_o    (res_id_o),
    .res_ovf_o   (res_ovf_o)
  );

  // Free-running clock and cycle counter
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Single comparison point: every check goes through here
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values
  function automatic expect_t modelOp(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic sub, input logic id);
    expect_t e;
    longint  ua, ub, ur;
`ifdef ADDSUB_SEQ_OVF_EN
    longint  sa, sb, sr;
`endif
    ua = longint'(a);
    ub = longint'(b);
    ur = sub ? ua - ub : ua + ub;
    e.data  = W'(ur);
    e.carry = sub ? (ur < 0) : (ur >= (longint'(1) << W));
`ifdef ADDSUB_SEQ_OVF_EN
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sr = sub ? sa - sb : sa + sb;
    e.ovf = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
`else
    e.ovf = 1'b0;
`endif
    e.id        = id;
    e.acceptCyc = 0;
    return e;
  endfunction

  // One cycle of requester/consumer drive, plus the model's view of the handshake
  task automatic applyStimulus(input logic nv0, input logic [W-1:0] na0, input logic [W-1:0] nb0,
                               input logic ns0, input logic nv1, input logic [W-1:0] na1,
                               input logic [W-1:0] nb1, input logic ns1, input logic nrr,
                               output logic acc);
    logic    expR0, expR1, g;
    expect_t e;
    @(posedge clk_i);
    #1;
    req0_valid_i = nv0; req0_a_i = na0; req0_b_i = nb0; req0_sub_i = ns0;
    req1_valid_i = nv1; req1_a_i = na1; req1_b_i = nb1; req1_sub_i = ns1;
    res_ready_i  = nrr;
    #2;
    expR0 = 1'b0;
    expR1 = 1'b0;
    acc   = 1'b0;
    if (!rst_i) begin
      if ((expQ.size() == 0) && (nv0 || nv1)) begin
        g         = (nv0 && nv1) ? ~lastGrant : nv1;
        expR0     = ~g;
        expR1     = g;
        lastGrant = g;
        acc       = 1'b1;
        e         = g ? modelOp(na1, nb1, ns1, 1'b1) : modelOp(na0, nb0, ns0, 1'b0);
        e.acceptCyc = cyc;
        expQ.push_back(e);
      end
      checkOutput("req0_ready", 64'(req0_ready_o), 64'(expR0));
      checkOutput("req1_ready", 64'(req1_ready_o), 64'(expR1));
    end
  endtask

  task automatic sendOne(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic rr);
    logic acc;
    int   n;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 40) begin
      if (id) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, a, b, sub, rr, acc);
      else    applyStimulus(1'b1, a, b, sub, 1'b0, '0, '0, 1'b0, rr, acc);
      n++;
    end
    if (!acc) checkOutput("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic waitDrain(input int budget);
    logic acc;
    int   n;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
      n++;
    end
    if (expQ.size() != 0) begin
      checkOutput("drain_timeout", 64'(expQ.size()), 64'(0));
      expQ.delete();
    end
  endtask

  // Reset for n edges, then verify every result output reads zero
  task automatic doReset(input int n);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    res_ready_i  = 1'b0;
    expQ.delete();
    lastGrant = 1'b1;
    repeat (n) @(posedge clk_i);
    #3;
    checkOutput("rst_res_valid", 64'(res_valid_o), 64'(0));
    checkOutput("rst_res_data",  64'(res_data_o),  64'(0));
    checkOutput("rst_res_carry", 64'(res_carry_o), 64'(0));
    checkOutput("rst_res_id",    64'(res_id_o),    64'(0));
    checkOutput("rst_res_ovf",   64'(res_ovf_o),   64'(0));
    checkOutput("rst_req0_ready", 64'(req0_ready_o), 64'(0));
    checkOutput("rst_req1_ready", 64'(req1_ready_o), 64'(0));
    #1;
    rst_i = 1'b0;
  endtask

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return W'(16'h8000);
      3:       return W'(16'h7FFF);
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: compare whatever result the DUT presents against the queue head
  always @(negedge clk_i) begin
    if (rst_i) begin
      prevValid = 1'b0;
      lateFlag  = 1'b0;
    end else begin
      if (res_valid_o) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_res_valid", 64'(1), 64'(0));
        end else begin
          if (!prevValid) checkOutput("latency", 64'(cyc - expQ[0].acceptCyc), 64'(LAT));
          checkOutput("res_data",  64'(res_data_o),  64'(expQ[0].data));
          checkOutput("res_carry", 64'(res_carry_o), 64'(expQ[0].carry));
          checkOutput("res_id",    64'(res_id_o),    64'(expQ[0].id));
          checkOutput("res_ovf",   64'(res_ovf_o),   64'(expQ[0].ovf));
          if (res_ready_i) begin
            void'(expQ.pop_front());
            lateFlag = 1'b0;
          end
        end
      end else if (expQ.size() != 0 && !lateFlag && (cyc - expQ[0].acceptCyc) > LAT) begin
        checkOutput("res_valid_timeout", 64'(0), 64'(1));
        lateFlag = 1'b1;
      end
      prevValid = res_valid_o && !res_ready_i;
    end
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: directed corner cases, then a randomized soak
  initial begin
    logic acc;
    rst_i = 1'b0;
    req0_valid_i = 1'b0; req0_a_i = '0; req0_b_i = '0; req0_sub_i = 1'b0;
    req1_valid_i = 1'b0; req1_a_i = '0; req1_b_i = '0; req1_sub_i = 1'b0;
    res_ready_i  = 1'b0;

    doReset(2);

    sendOne(1'b0, 16'h1234, 16'h0FFF, 1'b0, 1'b1);
    waitDrain(20);
    sendOne(1'b1, 16'h0001, 16'h0002, 1'b1, 1'b1);
    waitDrain(20);
    sendOne(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    waitDrain(20);
    sendOne(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b1);
    waitDrain(20);

    // Both requesters valid continuously from reset: grants must alternate 0,1,0,1
    doReset(1);
    for (int i = 0; i < 26; i++) begin
      applyStimulus(1'b1, pickOperand(), pickOperand(), 1'($urandom_range(0, 1)),
                    1'b1, pickOperand(), pickOperand(), 1'($urandom_range(0, 1)), 1'b1, acc);
    end
    waitDrain(20);

    // Consumer stalls ten cycles in DONE while both requesters keep asking
    sendOne(1'b0, 16'hABCD, 16'h1357, 1'b1, 1'b0);
    for (int i = 0; i < LAT - 1 + 10; i++) begin
      applyStimulus(1'b1, pickOperand(), pickOperand(), 1'b0,
                    1'b1, pickOperand(), pickOperand(), 1'b1, 1'b0, acc);
    end
    applyStimulus(1'b1, 16'h0102, 16'h0304, 1'b0, 1'b1, 16'h0506, 16'h0708, 1'b1, 1'b1, acc);
    waitDrain(20);

    // Reset in the second CALC cycle discards the operation; next tie goes to requester 0
    sendOne(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
    doReset(1);
    applyStimulus(1'b1, 16'h4444, 16'h1111, 1'b1, 1'b1, 16'h2222, 16'h3333, 1'b0, 1'b1, acc);
    waitDrain(20);

    // Randomized soak with random valids, operations and consumer back-pressure
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), pickOperand(), pickOperand(), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), pickOperand(), pickOperand(), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0), acc);
    end
    waitDrain(40);

    repeat (2) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
